// File: rtl/bus_rr_n.sv
// -----------------------------------------------------------------------------
// bus_rr_n
//
// Parametrised shared system bus: N_M masters, N_S slaves. A round-robin
// arbiter with a burst cap picks one owner, whose request is forwarded to the
// slaves. An address decoder on the top byte produces a one-hot slave select.
// Read data comes back one cycle later through a registered select.
//
// Handshake: there is no ready/stall. A master is granted when m_grant[i]=1
// (registered, one cycle after the request change). While granted and
// m_req[i]=1, every cycle is one address phase. Read data for that phase
// appears on m_din in the following cycle.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high reset
//   m_req    in   [N_M]         per-master request
//   m_wr     in   [N_M]         per-master write strobe
//   m_addr   in   [N_M*ADDR_W]  per-master address (master i in slice i)
//   m_dout   in   [N_M*DATA_W]  per-master write data
//   m_grant  out  [N_M]         one-hot grant (owner register decoded)
//   m_din    out  [DATA_W]      read data broadcast to all masters
//   s_dout   in   [N_S*DATA_W]  per-slave read data
//   s_sel    out  [N_S]         one-hot slave select, zero on idle/unmapped
//   s_addr   out  [ADDR_W]      address of the owner
//   s_wr     out                write strobe of the owner (gated by its req)
//   s_din    out  [DATA_W]      write data of the owner
//   s_err    out                registered decode error
//
// Optional feature macro: BUS_RR_ERR_EN
//   Defined:   err_q flags a requested but unmapped access; s_err = err_q and
//              m_din returns 32'hDEAD_BEEF (resized to DATA_W) while it is set.
//   Undefined: s_err is tied 0 and unmapped reads return 0.
// -----------------------------------------------------------------------------
module bus_rr_n #(
   parameter int         N_M       = 4,
   parameter int         N_S       = 8,
   parameter int         ADDR_W    = 16,
   parameter int         DATA_W    = 32,
   parameter logic [7:0] BASE_HI   = 8'h00,
   parameter int         MAX_BURST = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_M-1:0]          m_req,
   input  logic [N_M-1:0]          m_wr,
   input  logic [N_M*ADDR_W-1:0]   m_addr,
   input  logic [N_M*DATA_W-1:0]   m_dout,
   output logic [N_M-1:0]          m_grant,
   output logic [DATA_W-1:0]       m_din,
   input  logic [N_S*DATA_W-1:0]   s_dout,
   output logic [N_S-1:0]          s_sel,
   output logic [ADDR_W-1:0]       s_addr,
   output logic                    s_wr,
   output logic [DATA_W-1:0]       s_din,
   output logic                    s_err
);

   localparam int OW = $clog2(N_M);
   // Counter only needs to reach MAX_BURST-1; for unlimited or a cap of 1 it
   // stays at zero and a single bit is enough.
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] BURST_LAST = (MAX_BURST > 1) ? BW'(MAX_BURST - 1) : '0;
   localparam bit UNLIMITED = (MAX_BURST == 0);

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [OW-1:0]  owner_q, owner_d;
   logic [BW-1:0]  burst_q, burst_d;
   logic [N_S-1:0] sel_q;

   // --------------------------------------------------------------------------
   // Arbitration
   // --------------------------------------------------------------------------
   logic [N_M-1:0] owner_oh;
   logic           own_req;
   logic           others_req;
   logic           keep;
   logic           found;
   int             cand;

   assign owner_oh = N_M'(1) << owner_q;
   assign m_grant  = owner_oh;

   always_comb begin
      own_req    = m_req[owner_q];
      others_req = |(m_req & ~owner_oh);
      // The burst cap only forces a hand-off when someone else is waiting.
      keep       = own_req && (UNLIMITED || (burst_q < BURST_LAST) || !others_req);
      owner_d    = owner_q;
      found      = 1'b0;
      cand       = 0;
      if (!keep) begin
         // Scan owner+1, owner+2, ... wrapping; the owner itself is never a
         // candidate here, so with no other requester the owner stays parked.
         for (int k = 1; k < N_M; k++) begin
            cand = int'(owner_q) + k;
            if (cand >= N_M) begin
               cand = cand - N_M;
            end
            if (!found && m_req[OW'(cand)]) begin
               owner_d = OW'(cand);
               found   = 1'b1;
            end
         end
      end
   end

   always_comb begin
      burst_d = '0;
      if ((owner_d == owner_q) && own_req) begin
         burst_d = (burst_q == BURST_LAST) ? burst_q : burst_q + BW'(1);
      end
   end

   // --------------------------------------------------------------------------
   // Forwarding of the owner's slices
   // --------------------------------------------------------------------------
   assign s_addr = m_addr[owner_q*ADDR_W +: ADDR_W];
   assign s_din  = m_dout[owner_q*DATA_W +: DATA_W];
   assign s_wr   = m_wr[owner_q] & own_req;

   // --------------------------------------------------------------------------
   // Address decode on the top address byte
   // --------------------------------------------------------------------------
   logic [7:0] addr_hi;
   assign addr_hi = s_addr[ADDR_W-1 -: 8];

   for (genvar i = 0; i < N_S; i++) begin : g_dec
      localparam int SLV_HI = int'(BASE_HI) + i;
      if (SLV_HI <= 255) begin : g_map
         assign s_sel[i] = own_req && (addr_hi == 8'(SLV_HI));
      end else begin : g_unmap
         // Base would overflow the byte: slave is unreachable, no wrap-around.
         assign s_sel[i] = 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Read-data return: select registered with the address phase, data muxed
   // from the slave outputs in the following cycle.
   // --------------------------------------------------------------------------
   logic [N_S:0][DATA_W-1:0] rd_acc;
   assign rd_acc[0] = '0;
   for (genvar i = 0; i < N_S; i++) begin : g_rd
      assign rd_acc[i+1] = rd_acc[i] | (sel_q[i] ? s_dout[i*DATA_W +: DATA_W] : '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= '0;
         burst_q <= '0;
         sel_q   <= '0;
      end else begin
         owner_q <= owner_d;
         burst_q <= burst_d;
         sel_q   <= s_sel;
      end
   end

`ifdef BUS_RR_ERR_EN
   localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hDEAD_BEEF);
   logic err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= own_req & ~(|s_sel);
      end
   end

   assign s_err = err_q;
   // err_q and sel_q are never both active, so the override is unambiguous.
   assign m_din = err_q ? ERR_WORD : rd_acc[N_S];
`else
   assign s_err = 1'b0;
   assign m_din = rd_acc[N_S];
`endif

endmodule

// File: tb/tb_bus_rr_n.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_n: self-checking bench for bus_rr_n with default parameters.
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model of the arbitration/decode rules.
// -----------------------------------------------------------------------------
module tb_bus_rr_n;

   localparam int         N_M       = 4;
   localparam int         N_S       = 8;
   localparam int         ADDR_W    = 16;
   localparam int         DATA_W    = 32;
   localparam logic [7:0] BASE_HI   = 8'h00;
   localparam int         MAX_BURST = 16;
`ifdef BUS_RR_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam logic [DATA_W-1:0] ERR_WORD = 32'hDEAD_BEEF;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [N_M-1:0]        m_req;
   logic [N_M-1:0]        m_wr;
   logic [N_M*ADDR_W-1:0] m_addr;
   logic [N_M*DATA_W-1:0] m_dout;
   logic [N_M-1:0]        m_grant;
   logic [DATA_W-1:0]     m_din;
   logic [N_S*DATA_W-1:0] s_dout;
   logic [N_S-1:0]        s_sel;
   logic [ADDR_W-1:0]     s_addr;
   logic                  s_wr;
   logic [DATA_W-1:0]     s_din;
   logic                  s_err;

   bus_rr_n #(
      .N_M(N_M), .N_S(N_S), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .BASE_HI(BASE_HI), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .reset(reset),
      .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
      .m_grant(m_grant), .m_din(m_din),
      .s_dout(s_dout), .s_sel(s_sel), .s_addr(s_addr), .s_wr(s_wr),
      .s_din(s_din), .s_err(s_err)
   );

   // ---------------- scoreboard / model state ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [DATA_W-1:0] exp_q[$];   // expected m_din, one entry per clock edge
   int mdl_owner;                 // current owner index
   int mdl_held;                  // consecutive held cycles, capped at MAX_BURST-1
   bit mdl_err;                   // registered decode error

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Slave index addressed by a, or -1 when no slave owns that top byte.
   function automatic int slave_of(input logic [ADDR_W-1:0] a);
      int idx;
      idx = int'(a[ADDR_W-1 -: 8]) - int'(BASE_HI);
      return (idx >= 0 && idx < N_S) ? idx : -1;
   endfunction

   function automatic logic [ADDR_W-1:0] rand_addr();
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom());
      a[ADDR_W-1 -: 8] = 8'(int'(BASE_HI) + int'($urandom_range(0, N_S + 3)));
      return a;
   endfunction

   // Outputs that must hold in the current cycle given model state + inputs.
   task automatic model_check();
      int o;
      int sl;
      bit oreq;
      logic [ADDR_W-1:0] a;
      o    = mdl_owner;
      oreq = m_req[o];
      a    = m_addr[o*ADDR_W +: ADDR_W];
      sl   = oreq ? slave_of(a) : -1;
      check("grant",  64'(m_grant), 64'(1) << o);
      check("s_addr", 64'(s_addr),  64'(a));
      check("s_wr",   64'(s_wr),    64'(oreq & m_wr[o]));
      check("s_din",  64'(s_din),   64'(m_dout[o*DATA_W +: DATA_W]));
      check("s_sel",  64'(s_sel),   (sl >= 0) ? (64'(1) << sl) : 64'(0));
      check("s_err",  64'(s_err),   64'(ERR_EN & mdl_err));
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL m_din: no expected read data queued");
      end else begin
         check("m_din", 64'(m_din), 64'(exp_q.pop_front()));
      end
   endtask

   // Advance the model at a rising edge using the inputs presented to it.
   task automatic model_update();
      int o;
      int sl;
      int nxt;
      bit oreq;
      bit others;
      if (reset) begin
         mdl_owner = 0;
         mdl_held  = 0;
         mdl_err   = 1'b0;
         exp_q.push_back('0);
         return;
      end
      o      = mdl_owner;
      oreq   = m_req[o];
      sl     = oreq ? slave_of(m_addr[o*ADDR_W +: ADDR_W]) : -1;
      others = (m_req & ~(N_M'(1) << o)) != '0;
      mdl_err = oreq && (sl < 0);
      if (ERR_EN && mdl_err)  exp_q.push_back(ERR_WORD);
      else if (sl >= 0)       exp_q.push_back(s_dout[sl*DATA_W +: DATA_W]);
      else                    exp_q.push_back('0);
      nxt = o;
      if (!(oreq && (MAX_BURST == 0 || mdl_held < MAX_BURST - 1 || !others))) begin
         for (int k = N_M - 1; k >= 1; k--) begin
            if (m_req[(o + k) % N_M]) nxt = (o + k) % N_M;
         end
      end
      if (nxt == o && oreq) begin
         if (MAX_BURST == 0 || mdl_held < MAX_BURST - 1) mdl_held++;
      end else begin
         mdl_held = 0;
      end
      mdl_owner = nxt;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      #1;
      model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic drive_master(input int i, input bit req, input bit wr,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      m_req[i] = req;
      m_wr[i]  = wr;
      m_addr[i*ADDR_W +: ADDR_W] = addr;
      m_dout[i*DATA_W +: DATA_W] = data;
   endtask

   task automatic idle_all();
      m_req  = '0;
      m_wr   = '0;
      m_addr = '0;
      m_dout = '0;
   endtask

   task automatic do_reset();
      idle_all();
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      model_update();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic rand_slaves();
      for (int i = 0; i < N_S; i++) s_dout[i*DATA_W +: DATA_W] = $urandom();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [DATA_W-1:0] d5;
      logic [N_M-1:0]    g_exp;
      reset  = 1'b1;
      s_dout = '0;
      idle_all();
      mdl_owner = 0;
      mdl_held  = 0;
      mdl_err   = 1'b0;

      // Reset then idle: master 0 parked, nothing selected.
      do_reset();
      rand_slaves();
      repeat (10) begin
         #1;
         check("idle_grant", 64'(m_grant), 64'h1);
         check("idle_sel",   64'(s_sel),   64'h0);
         check("idle_din",   64'(m_din),   64'h0);
         check("idle_err",   64'(s_err),   64'h0);
         step();
      end

      // Masters 1 and 2 request continuously: burst cap rotates the grant.
      do_reset();
      drive_master(1, 1'b1, 1'b0, 16'h0100, 32'h0);
      drive_master(2, 1'b1, 1'b0, 16'h0200, 32'h0);
      for (int j = 0; j <= 40; j++) begin
         if (j == 0)       g_exp = 4'b0001;
         else if (j <= 16) g_exp = 4'b0010;
         else if (j <= 32) g_exp = 4'b0100;
         else              g_exp = 4'b0010;
         #1;
         check("burst_grant", 64'(m_grant), 64'(g_exp));
         step();
      end

      // Master 3 alone reads slave 3.
      do_reset();
      s_dout[3*DATA_W +: DATA_W] = 32'h1234_5678;
      drive_master(3, 1'b1, 1'b0, 16'h0310, 32'h0);
      step();
      #1;
      check("m3_sel", 64'(s_sel), 64'h08);
      step();
      #1;
      check("m3_rdata", 64'(m_din), 64'h1234_5678);
      step();

      // Master 0 writes slave 0.
      do_reset();
      drive_master(0, 1'b1, 1'b1, 16'h0004, 32'hCAFE_0001);
      #1;
      check("wr_strobe", 64'(s_wr),  64'h1);
      check("wr_sel",    64'(s_sel), 64'h01);
      check("wr_data",   64'(s_din), 64'hCAFE_0001);
      step();
      m_req[0] = 1'b0;
      #1;
      check("wr_release", 64'(s_wr), 64'h0);
      step();

      // Unmapped address.
      do_reset();
      drive_master(0, 1'b1, 1'b0, 16'h0900, 32'h0);
      #1;
      check("unmap_sel", 64'(s_sel), 64'h0);
      step();
      #1;
      check("unmap_err",  64'(s_err), ERR_EN ? 64'h1 : 64'h0);
      check("unmap_din",  64'(m_din), ERR_EN ? 64'hDEAD_BEEF : 64'h0);
      step();

      // Reset while master 2 owns and reads slave 5.
      do_reset();
      d5 = $urandom() | 32'h1;
      s_dout[5*DATA_W +: DATA_W] = d5;
      drive_master(2, 1'b1, 1'b0, 16'h0500, 32'h0);
      step();
      #1;
      check("m2_sel", 64'(s_sel), 64'h20);
      step();
      reset = 1'b1;
      #1;
      check("m2_rdata", 64'(m_din), 64'(d5));
      step();
      reset = 1'b0;
      #1;
      check("rst_grant", 64'(m_grant), 64'h1);
      check("rst_din",   64'(m_din),   64'h0);
      step();

      // Randomized traffic with occasional resets.
      do_reset();
      rand_slaves();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N_M; i++) begin
            if ($urandom_range(0, 9) < 3) begin
               drive_master(i, $urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1,
                            rand_addr(), $urandom());
            end
         end
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
